// File: rtl/rename_ctrl_pkg.sv
// Shared rename-stage definitions: sizes, index types, controller state enum,
// and the modular free-list pointer increment.
package rename_ctrl_pkg;
    localparam int PREG_WIDTH = 7;
    localparam int AREG_COUNT = 32;
    localparam int AREG_WIDTH = $clog2(AREG_COUNT);
    localparam int FL_DEPTH   = (2 ** PREG_WIDTH) - AREG_COUNT;
    localparam int PTR_W      = $clog2(FL_DEPTH);
    localparam int CNT_W      = $clog2(FL_DEPTH + 1);
    localparam int RCV_W      = AREG_WIDTH - 1;
    localparam int RCV_LAST   = AREG_COUNT / 2 - 1;

    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [AREG_WIDTH-1:0] areg_t;
    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    typedef enum logic {RUN, RECOVER} rename_state_e;

    // Advance a free-list pointer by 0..2; the depth need not be a power of two.
    function automatic ptr_t ptr_add(ptr_t p, logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
        if (s >= (PTR_W+1)'(FL_DEPTH)) s = s - (PTR_W+1)'(FL_DEPTH);
        return s[PTR_W-1:0];
    endfunction
endpackage

// File: rtl/rename_freelist.sv
// Physical-register free list: circular array with alloc head, free tail and
// committed head. A flush rewinds head to the committed head and marks every
// non-architectural preg free.
// Ports: alloc_n_i (pregs taken this cycle), free_i/free_pd_i (per-slot frees),
// flush_i, pd_o (entry[head], entry[head+1]), cnt_o (free count), err_o.
// Optional macro RENAME_CTRL_CHECK_EN: sticky over/underflow error with
// saturated count; when undefined err_o is tied low.
module rename_freelist import rename_ctrl_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       alloc_n_i,
    input  logic [1:0]       free_i,
    input  preg_t [1:0]      free_pd_i,
    input  logic             flush_i,
    output preg_t [1:0]      pd_o,
    output cnt_t             cnt_o,
    output logic             err_o
);
    preg_t      fl_q [FL_DEPTH];
    preg_t      fl_d [FL_DEPTH];
    ptr_t       head_q, head_d, tail_q, tail_d, cmt_head_q, cmt_head_d;
    cnt_t       cnt_q, cnt_d;
    logic [1:0] n_free;
    int         cnt_sum;

    assign pd_o[0] = fl_q[head_q];
    assign pd_o[1] = fl_q[ptr_add(head_q, 2'd1)];
    assign cnt_o   = cnt_q;

    always_comb begin
        fl_d    = fl_q;
        n_free  = {1'b0, free_i[0]} + {1'b0, free_i[1]};
        // Frees pack into consecutive tail slots in slot order.
        if (free_i[0]) fl_d[tail_q] = free_pd_i[0];
        if (free_i[1]) fl_d[free_i[0] ? ptr_add(tail_q, 2'd1) : tail_q] = free_pd_i[1];
        tail_d     = ptr_add(tail_q, n_free);
        cmt_head_d = ptr_add(cmt_head_q, n_free);
        head_d     = ptr_add(head_q, alloc_n_i);
        cnt_sum    = int'(cnt_q) - int'(alloc_n_i) + int'(n_free);
        cnt_d      = cnt_t'(cnt_sum);
`ifdef RENAME_CTRL_CHECK_EN
        if (cnt_sum > FL_DEPTH) cnt_d = cnt_t'(FL_DEPTH);
        else if (cnt_sum < 0)   cnt_d = '0;
`endif
        // Commits of the flush cycle land first, then everything speculative is freed.
        if (flush_i) begin
            head_d = cmt_head_d;
            cnt_d  = cnt_t'(FL_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= preg_t'(i + AREG_COUNT);
            head_q     <= '0;
            tail_q     <= '0;
            cmt_head_q <= '0;
            cnt_q      <= cnt_t'(FL_DEPTH);
        end else begin
            fl_q       <= fl_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cmt_head_q <= cmt_head_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef RENAME_CTRL_CHECK_EN
    logic err_q, err_d;
    always_comb begin
        err_d = err_q | (cnt_sum > FL_DEPTH) | (cnt_t'(alloc_n_i) > cnt_q);
    end
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: rtl/rename_ctrl.sv
// Two-wide rename-stage controller: allocates pregs from the free list, drives
// the speculative RAT write ports, keeps the committed map, and after a flush
// replays the committed map into the RAT two entries per cycle.
// Ports: dec_* decode group in (valid/ready), ren_* registered group out,
// rat_* RAT write ports, cmt_* retiring slots, flush_i, busy_o (recovery),
// err_o (free-list error, only with RENAME_CTRL_CHECK_EN defined).
module rename_ctrl import rename_ctrl_pkg::*; (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 dec_valid_i,
    input  logic [1:0]                 dec_we_i,
    input  logic [1:0][AREG_WIDTH-1:0] dec_rd_i,
    output logic                       dec_ready_o,
    output logic                       ren_valid_o,
    input  logic                       ren_ready_i,
    output logic [1:0]                 ren_slot_o,
    output logic [1:0][PREG_WIDTH-1:0] ren_pd_o,
    output logic [1:0]                 rat_we_o,
    output logic [1:0][AREG_WIDTH-1:0] rat_waddr_o,
    output logic [1:0][PREG_WIDTH-1:0] rat_wdata_o,
    input  logic [1:0]                 cmt_valid_i,
    input  logic [1:0]                 cmt_we_i,
    input  logic [1:0][AREG_WIDTH-1:0] cmt_rd_i,
    input  logic [1:0][PREG_WIDTH-1:0] cmt_pd_i,
    input  logic [1:0][PREG_WIDTH-1:0] cmt_old_pd_i,
    input  logic                       flush_i,
    output logic                       busy_o,
    output logic                       err_o
);
    rename_state_e state_q;
    logic [RCV_W-1:0] c_q;
    logic          busy_q;
    logic [1:0]    dec_eff, cmt_eff, n_alloc;
    logic          accept;
    preg_t [1:0]   fl_pd, alloc_pd;
    cnt_t          fl_cnt;
    preg_t         arch_q [AREG_COUNT];
    preg_t         arch_d [AREG_COUNT];
    logic          ren_valid_q, ren_valid_d;
    logic [1:0]    ren_slot_q, ren_slot_d;
    preg_t [1:0]   ren_pd_q, ren_pd_d;

    // r0 is hard-wired: never allocated, never remapped, never freed.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dec_eff[i] = dec_valid_i[i] & dec_we_i[i] & (dec_rd_i[i] != '0);
            cmt_eff[i] = cmt_valid_i[i] & cmt_we_i[i] & (cmt_rd_i[i] != '0);
        end
    end

    // Two free entries are required even for groups that allocate fewer.
    assign dec_ready_o = (state_q == RUN) & !flush_i & (fl_cnt >= cnt_t'(2)) &
                         (!ren_valid_q | ren_ready_i);
    assign accept  = dec_valid_i[0] & dec_ready_o;
    assign n_alloc = accept ? ({1'b0, dec_eff[0]} + {1'b0, dec_eff[1]}) : 2'd0;

    always_comb begin
        alloc_pd[0] = dec_eff[0] ? fl_pd[0] : '0;
        alloc_pd[1] = !dec_eff[1] ? '0 : (dec_eff[0] ? fl_pd[1] : fl_pd[0]);
    end

    rename_freelist u_fl (
        .clk       (clk),
        .rst       (rst),
        .alloc_n_i (n_alloc),
        .free_i    (cmt_eff),
        .free_pd_i (cmt_old_pd_i),
        .flush_i   (flush_i),
        .pd_o      (fl_pd),
        .cnt_o     (fl_cnt),
        .err_o     (err_o)
    );

    always_comb begin
        rat_we_o    = '0;
        rat_waddr_o = dec_rd_i;
        rat_wdata_o = alloc_pd;
        if (state_q == RECOVER) begin
            rat_we_o       = 2'b11;
            rat_waddr_o[0] = {c_q, 1'b0};
            rat_waddr_o[1] = {c_q, 1'b1};
            rat_wdata_o[0] = arch_q[{c_q, 1'b0}];
            rat_wdata_o[1] = arch_q[{c_q, 1'b1}];
        end else if (accept) begin
            rat_we_o = dec_eff;
        end
    end

    // Committed map; slot 1 is applied last so it wins on equal rd.
    always_comb begin
        arch_d = arch_q;
        for (int i = 0; i < 2; i++)
            if (cmt_eff[i]) arch_d[cmt_rd_i[i]] = cmt_pd_i[i];
    end

    always_comb begin
        ren_valid_d = ren_valid_q;
        ren_slot_d  = ren_slot_q;
        ren_pd_d    = ren_pd_q;
        if (flush_i) begin
            ren_valid_d = 1'b0;
            ren_slot_d  = '0;
            ren_pd_d    = '0;
        end else if (accept) begin
            ren_valid_d = 1'b1;
            ren_slot_d  = dec_valid_i;
            ren_pd_d    = alloc_pd;
        end else if (ren_ready_i) begin
            ren_valid_d = 1'b0;
            ren_slot_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < AREG_COUNT; i++) arch_q[i] <= preg_t'(i);
            ren_valid_q <= 1'b0;
            ren_slot_q  <= '0;
            ren_pd_q    <= '0;
        end else begin
            arch_q      <= arch_d;
            ren_valid_q <= ren_valid_d;
            ren_slot_q  <= ren_slot_d;
            ren_pd_q    <= ren_pd_d;
        end
    end

    // Recovery FSM: c walks register pairs; a flush mid-recovery starts over.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            c_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: if (flush_i) begin
                    state_q <= RECOVER;
                    c_q     <= '0;
                    busy_q  <= 1'b1;
                end
                RECOVER: begin
                    if (flush_i) begin
                        c_q <= '0;
                    end else if (c_q == RCV_W'(RCV_LAST)) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign ren_valid_o = ren_valid_q;
    assign ren_slot_o  = ren_slot_q;
    assign ren_pd_o    = ren_pd_q;
endmodule

// File: tb/tb_rename_ctrl.sv
module tb_rename_ctrl;
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       dec_valid_i, dec_we_i;
    logic [1:0][4:0]  dec_rd_i;
    logic             dec_ready_o, ren_valid_o, ren_ready_i;
    logic [1:0]       ren_slot_o;
    logic [1:0][6:0]  ren_pd_o;
    logic [1:0]       rat_we_o;
    logic [1:0][4:0]  rat_waddr_o;
    logic [1:0][6:0]  rat_wdata_o;
    logic [1:0]       cmt_valid_i, cmt_we_i;
    logic [1:0][4:0]  cmt_rd_i;
    logic [1:0][6:0]  cmt_pd_i, cmt_old_pd_i;
    logic             flush_i, busy_o, err_o;

    int checks = 0;
    int failures = 0;
    int exp_arch [32];

`ifdef RENAME_CTRL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    rename_ctrl dut (
        .clk(clk), .rst(rst),
        .dec_valid_i(dec_valid_i), .dec_we_i(dec_we_i), .dec_rd_i(dec_rd_i),
        .dec_ready_o(dec_ready_o), .ren_valid_o(ren_valid_o), .ren_ready_i(ren_ready_i),
        .ren_slot_o(ren_slot_o), .ren_pd_o(ren_pd_o),
        .rat_we_o(rat_we_o), .rat_waddr_o(rat_waddr_o), .rat_wdata_o(rat_wdata_o),
        .cmt_valid_i(cmt_valid_i), .cmt_we_i(cmt_we_i), .cmt_rd_i(cmt_rd_i),
        .cmt_pd_i(cmt_pd_i), .cmt_old_pd_i(cmt_old_pd_i),
        .flush_i(flush_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pp(input int hi, input int lo);
        return {18'b0, 7'(hi), 7'(lo)};
    endfunction

    function automatic logic [31:0] aa(input int hi, input int lo);
        return {22'b0, 5'(hi), 5'(lo)};
    endfunction

    task automatic cmt_clear();
        cmt_valid_i = '0; cmt_we_i = '0; cmt_rd_i = '0; cmt_pd_i = '0; cmt_old_pd_i = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_arch[i] = i;
        rst = 1'b1; flush_i = 1'b0; ren_ready_i = 1'b1;
        dec_valid_i = '0; dec_we_i = '0; dec_rd_i = '0;
        cmt_clear();
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ren_valid", 32'(ren_valid_o), 0);
        chk("rst_ren_slot",  32'(ren_slot_o), 0);
        chk("rst_ren_pd",    32'(ren_pd_o), 0);
        chk("rst_rat_we",    32'(rat_we_o), 0);
        chk("rst_busy",      32'(busy_o), 0);
        chk("rst_err",       32'(err_o), 0);
        chk("rst_dec_ready", 32'(dec_ready_o), 1);

        // Group {rd6, rd5}: pregs 32/33 from the reset free list.
        dec_valid_i = 2'b11; dec_we_i = 2'b11; dec_rd_i = {5'd6, 5'd5};
        #1;
        chk("g1_rat_we",    32'(rat_we_o), 3);
        chk("g1_rat_waddr", 32'(rat_waddr_o), aa(6, 5));
        chk("g1_rat_wdata", 32'(rat_wdata_o), pp(33, 32));
        tick();
        chk("g1_ren_valid", 32'(ren_valid_o), 1);
        chk("g1_ren_slot",  32'(ren_slot_o), 3);
        chk("g1_ren_pd",    32'(ren_pd_o), pp(33, 32));

        // Slot 0 writes r0: suppressed; slot 1 gets next free entry (34).
        dec_rd_i = {5'd7, 5'd0};
        #1;
        chk("r0_rat_we",    32'(rat_we_o), 2);
        chk("r0_rat_wdata", 32'(rat_wdata_o[1]), 34);
        chk("r0_rat_waddr", 32'(rat_waddr_o[1]), 7);
        tick();
        chk("r0_ren_pd",    32'(ren_pd_o), pp(34, 0));

        // Backpressure: output holds, nothing allocated.
        ren_ready_i = 1'b0; dec_rd_i = {5'd9, 5'd8};
        #1;
        chk("bp_dec_ready", 32'(dec_ready_o), 0);
        chk("bp_rat_we",    32'(rat_we_o), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", 32'(ren_valid_o), 1);
            chk("bp_hold_pd",    32'(ren_pd_o), pp(34, 0));
        end
        ren_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 32'(dec_ready_o), 1);
        chk("bp_release_wdata", 32'(rat_wdata_o), pp(36, 35));
        tick();
        chk("bp_ren_pd", 32'(ren_pd_o), pp(36, 35));

        // Drain free list: 91 free -> 44 groups of two -> 3 free.
        dec_rd_i = {5'd2, 5'd1};
        for (int g = 0; g < 44; g++) begin
            #1;
            chk("fill_ready", 32'(dec_ready_o), 1);
            chk("fill_wdata", 32'(rat_wdata_o), pp(38 + 2*g, 37 + 2*g));
            tick();
        end
        #1;
        chk("cnt3_ready", 32'(dec_ready_o), 1);
        chk("cnt3_wdata", 32'(rat_wdata_o), pp(126, 125));
        tick();
        #1;
        chk("cnt1_ready", 32'(dec_ready_o), 0);
        chk("cnt1_rat_we", 32'(rat_we_o), 0);

        // Commit {rd5, pd32, old5}: frees preg 5 into entry 0.
        dec_valid_i = '0;
        cmt_valid_i = 2'b01; cmt_we_i = 2'b01; cmt_rd_i[0] = 5'd5;
        cmt_pd_i[0] = 7'd32; cmt_old_pd_i[0] = 7'd5;
        exp_arch[5] = 32;
        #1;
        chk("cmt_ready_same_cycle", 32'(dec_ready_o), 0);
        tick();
        cmt_clear();
        #1;
        chk("cmt_ready_after", 32'(dec_ready_o), 1);

        // Allocation wraps: entry[95]=127 then entry[0]=5.
        dec_valid_i = 2'b11; dec_rd_i = {5'd6, 5'd5};
        #1;
        chk("wrap_wdata", 32'(rat_wdata_o), pp(5, 127));
        tick();
        dec_valid_i = '0;
        #1;
        chk("empty_ready", 32'(dec_ready_o), 0);

        // Flush and full recovery.
        flush_i = 1'b1;
        #1;
        chk("flush_ready", 32'(dec_ready_o), 0);
        chk("flush_rat_we", 32'(rat_we_o), 0);
        tick();
        flush_i = 1'b0;
        chk("rcv_busy", 32'(busy_o), 1);
        chk("rcv_ren_valid", 32'(ren_valid_o), 0);
        for (int c = 0; c < 16; c++) begin
            chk("rcv_we",    32'(rat_we_o), 3);
            chk("rcv_waddr", 32'(rat_waddr_o), aa(2*c + 1, 2*c));
            chk("rcv_wdata", 32'(rat_wdata_o), pp(exp_arch[2*c + 1], exp_arch[2*c]));
            chk("rcv_ready", 32'(dec_ready_o), 0);
            tick();
        end
        chk("rcv_done_busy",  32'(busy_o), 0);
        chk("rcv_done_ready", 32'(dec_ready_o), 1);
        chk("rcv_done_we",    32'(rat_we_o), 0);

        // head rewound to committed head (1): pregs 33/34.
        dec_valid_i = 2'b11; dec_rd_i = {5'd6, 5'd5};
        #1;
        chk("post_flush_wdata", 32'(rat_wdata_o), pp(34, 33));
        tick();
        dec_valid_i = '0;

        // Flush, then flush again at c=8: counter restarts.
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (8) tick();
        chk("c8_waddr", 32'(rat_waddr_o), aa(17, 16));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("restart_waddr", 32'(rat_waddr_o), aa(1, 0));
        chk("restart_busy",  32'(busy_o), 1);
        // Two commits to rd3 while recovering: slot 1 wins, read live at c=1.
        cmt_valid_i = 2'b11; cmt_we_i = 2'b11; cmt_rd_i = {5'd3, 5'd3};
        cmt_pd_i = {7'd41, 7'd40}; cmt_old_pd_i = {7'd40, 7'd3};
        exp_arch[3] = 41;
        tick();
        cmt_clear();
        for (int c = 1; c < 16; c++) begin
            chk("rs_busy",  32'(busy_o), 1);
            chk("rs_waddr", 32'(rat_waddr_o), aa(2*c + 1, 2*c));
            chk("rs_wdata", 32'(rat_wdata_o), pp(exp_arch[2*c + 1], exp_arch[2*c]));
            tick();
        end
        chk("rs_done_busy",  32'(busy_o), 0);
        chk("rs_done_ready", 32'(dec_ready_o), 1);

        // Free with a full free list.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_after_rst", 32'(err_o), 0);
        cmt_valid_i = 2'b01; cmt_we_i = 2'b01; cmt_rd_i[0] = 5'd4;
        cmt_pd_i[0] = 7'd50; cmt_old_pd_i[0] = 7'd4;
        tick();
        cmt_clear();
        chk("err_set", 32'(err_o), 32'(EXP_ERR));
        tick(); tick();
        chk("err_sticky", 32'(err_o), 32'(EXP_ERR));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", 32'(err_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rename_ctrl.md
# rename_ctrl

Two-wide rename-stage controller. It owns the physical-register free list and the committed (architectural) map table, and drives the two write ports of the speculative rename RAT. On each accepted decode group it allocates up to two physical registers and writes the new mappings into the RAT. After a pipeline flush, a recovery state machine rebuilds the speculative RAT from the committed map, two entries per cycle.

## Interface
Parameters:
- PREG_WIDTH, 7: physical register index width, giving 128 pregs.
- AREG_COUNT, 32: architectural registers. AREG_WIDTH = $clog2(AREG_COUNT).
- FL_DEPTH, 2**PREG_WIDTH - AREG_COUNT (96): free-list entries. Need not be a power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- dec_valid_i  in  2  per-slot decode valid. Slot 1 is valid only if slot 0 is valid.
- dec_we_i  in  2  slot writes a destination.
- dec_rd_i  in  2×AREG_WIDTH  destination architectural register.
- dec_ready_o  out  1  group accepted this cycle when dec_valid_i[0] & dec_ready_o.
- ren_valid_o  out  1  registered output group valid.
- ren_ready_i  in  1  downstream accepts the output group.
- ren_slot_o  out  2  registered slot valids.
- ren_pd_o  out  2×PREG_WIDTH  allocated pregs. 0 where the slot has no destination.
- rat_we_o  out  2  RAT write enables.
- rat_waddr_o  out  2×AREG_WIDTH  RAT write addresses.
- rat_wdata_o  out  2×PREG_WIDTH  RAT write data.
- cmt_valid_i  in  2  retiring slots.
- cmt_we_i  in  2  retiring slot had a destination.
- cmt_rd_i  in  2×AREG_WIDTH  retiring slot's architectural destination.
- cmt_pd_i  in  2×PREG_WIDTH  retiring slot's new preg.
- cmt_old_pd_i  in  2×PREG_WIDTH  retiring slot's previous mapping, to be freed.
- flush_i  in  1  squash all uncommitted state.
- busy_o  out  1  recovery in progress.
- err_o  out  1  sticky free-list error. See Configuration.

## Operation
Free list:
- Circular array of FL_DEPTH entries with pointers head (alloc), tail (free) and cmt_head.
- Free count is cnt, range 0..FL_DEPTH.
- Pointers wrap explicitly from FL_DEPTH-1 to 0.
- Reset: entry i = i + AREG_COUNT, head = tail = cmt_head = 0, cnt = FL_DEPTH.

Effective destination:
- A slot's effective destination is valid & we & (rd != 0).
- r0 is never renamed: its RAT write is suppressed and ren_pd_o = 0.
- n_alloc = the number of effective destinations in the group (0..2).

Accept:
- dec_ready_o = state==RUN & !flush_i & cnt >= 2 & (!ren_valid_o | ren_ready_i).
- cnt >= 2 is checked regardless of n_alloc.
- On accept:
  - Slot 0 takes entry[head] if it has a destination; the next destination takes the next entry.
  - head advances by n_alloc.
  - rat_we_o, rat_waddr_o and rat_wdata_o are driven combinationally in the same cycle.
  - The output register loads.
- When both slots write the same rd, slot 1 wins. The RAT already gives port 1 priority.

Commit:
- Each cmt slot with valid & we & rd != 0:
  - writes cmt_old_pd_i to entry[tail], then tail++;
  - writes the committed map: arch[rd] <= cmt_pd_i;
  - advances cmt_head.
- When both commit slots target the same rd, slot 1 wins.

Count update:
- cnt next = cnt - n_alloc + n_free.

Flush:
- All commits presented in the flush cycle apply first.
- Then head <= the updated cmt_head and cnt <= FL_DEPTH, because every non-architectural preg is free.
- ren_valid_o clears.
- The FSM enters RECOVER.

FSM:
- RUN: normal operation. Moves to RECOVER on flush_i.
- RECOVER:
  - A 4-bit counter c runs 0..AREG_COUNT/2-1.
  - Each cycle: rat_we_o = 2'b11, rat_waddr_o = {2c+1, 2c}, rat_wdata_o = {arch[2c+1], arch[2c]}.
  - After c = 15 the FSM returns to RUN.
  - flush_i during RECOVER restarts c at 0.
  - busy_o = (state == RECOVER).
- Reset: state = RUN. Committed map is identity (arch[i] = i), matching the RAT's reset contents.

## Timing
- Rename latency is 1 cycle: the accepted group appears on ren_* the next cycle.
- RAT writes occur in the accept cycle.
- The output register holds its value while ren_valid_o & !ren_ready_i.
- Recovery takes exactly 16 cycles. The first RAT copy is in the cycle after flush_i. dec_ready_o returns in the cycle after the last copy.
- Commits are accepted in every state. Recovery reads the committed map live.
- Reset values: ren_valid_o = 0, ren_slot_o = 0, ren_pd_o = 0, rat_we_o = 0, busy_o = 0, err_o = 0, dec_ready_o = 1.
- rst takes priority over flush_i.

## Configuration
RENAME_CTRL_CHECK_EN:
- Defined: err_o latches 1, until rst, when either:
  - a free would make cnt exceed FL_DEPTH, or
  - n_alloc exceeds cnt.
  The offending update is still applied, saturated at the bounds.
- Undefined: err_o is tied to 0 and the check logic is absent.

## Structure
- Shared rename package holds: PREG_WIDTH, AREG_COUNT, FL_DEPTH, the `rename_state_e` enum {RUN, RECOVER}, and the typedefs `preg_t`/`areg_t`.
- One sub-module: `rename_freelist` (array, pointers, modular increment-by-0/1/2, cnt, flush rewind).
- FSM, committed map, output register and RAT mux stay in rename_ctrl.

## Test plan
- After reset, a group of {rd 5, rd 6} → ren_pd_o = {33, 32}, RAT writes 5→32 and 6→33, cnt = 94.
- A group with rd 0 in slot 0 and rd 7 in slot 1 → slot 0 pd = 0 with its RAT write suppressed, slot 1 gets 32, cnt = 95.
- Allocate 47 groups of two without commits → cnt = 2, next group accepted. With cnt = 1, dec_ready_o = 0 until a commit frees a preg.
- Commit {rd 5, pd 32, old 5}, then flush → 16 RECOVER cycles, RAT addresses 10/11 get {arch[11], arch[10]} at c = 5, arch[5] = 32, cnt = 96, head = 1.
- Hold ren_ready_i low for 3 cycles → ren_* is stable and no allocation happens. flush_i at c = 8 of recovery → counter restarts and recovery ends 16 cycles later.
- With RENAME_CTRL_CHECK_EN defined, free a preg when cnt = 96 → err_o = 1 next cycle and stays 1 until rst.
